clock_divider_bank: RTL and testbench

//  Multi-channel programmable clock-enable generator. Each channel divides clk_in by a runtime

---
 rtl/clkdiv_pkg.sv | 20 ++
 rtl/clock_divider_bank_if.sv | 42 ++++
 rtl/clkdiv_channel.sv | 85 ++++++++
 rtl/clock_divider_bank.sv | 68 ++++++
 tb/tb_clock_divider_bank.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// ============================================================================
//  clkdiv_pkg
//  Shared defaults and helpers for the clock divider bank.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package clkdiv_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int DIV_DEFAULT   = 1042;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : clkdiv_pkg

`default_nettype wire

// File: rtl/clock_divider_bank_if.sv
// ============================================================================
//  clock_divider_bank_if
//  Control/status bundle for the clock divider bank: run enables, restart,
//  divisor write port, and the per-channel tick / square-wave outputs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface clock_divider_bank_if
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEFAULT
) ();

  localparam int CH_W = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic              sync_restart;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  // Controller side: drives configuration, observes the divider outputs.
  modport master (
    output en, sync_restart, cfg_we, cfg_ch, cfg_div,
    input  cfg_err, pending, tick, clk_out
  );

  // Divider bank side.
  modport slave (
    input  en, sync_restart, cfg_we, cfg_ch, cfg_div,
    output cfg_err, pending, tick, clk_out
  );

endinterface : clock_divider_bank_if

`default_nettype wire

// File: rtl/clkdiv_channel.sv
// ============================================================================
//  clkdiv_channel
//  One divider channel: up-counter with active and shadow divisors. Emits a
//  1-cycle tick and toggles clk_out at each terminal count. Shadowed divisor
//  changes land only on a period boundary so no runt periods are produced.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  wire logic             clk_in,
  input  wire logic             rst,
  input  wire logic             en,
  input  wire logic             sync_restart,
  input  wire logic             wr,
  input  wire logic [CNT_W-1:0] wdata,
  output logic                  pending,
  output logic                  tick,
  output logic                  clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic             halted;
  logic             at_terminal;

  // A zero divisor parks the channel; the >= compare is a safe upper bound.
  assign halted      = (div_act == '0);
  assign at_terminal = (cnt >= (div_act - CNT_W'(1)));

  // Counter, divisor shadowing and output generation, in priority order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= CNT_W'(DEFAULT_DIV);
      div_shd <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b1;
    end else if (sync_restart) begin
      // Phase-align: a same-cycle write beats any older shadow value.
      cnt     <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b0;
      pending <= 1'b0;
      if (wr)           div_act <= wdata;
      else if (pending) div_act <= div_shd;
    end else if (wr && (!en || halted)) begin
      // Not running, so there is no period to protect: apply at once.
      div_act <= wdata;
      cnt     <= '0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else if (en && !halted) begin
      if (at_terminal) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= ~clk_out;
        if (pending) begin
          div_act <= div_shd;
          pending <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // A write on the boundary edge is held for the following boundary.
      if (wr) begin
        div_shd <= wdata;
        pending <= 1'b1;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule : clkdiv_channel

`default_nettype wire

// File: rtl/clock_divider_bank.sv
// ============================================================================
//  clock_divider_bank
//  Multi-channel programmable clock-enable generator. Decodes divisor writes
//  to the addressed channel and flags writes to nonexistent channels.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  wire logic           clk_in,
  input  wire logic           rst,
  clock_divider_bank_if.slave bus
);

  localparam int CH_W = clog2_min1(NUM_CH);

  logic [CH_W:0]     ch_ext;
  logic              ch_ok;
  logic              cfg_err;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  assign ch_ext = {1'b0, bus.cfg_ch};
  assign ch_ok  = (ch_ext < (CH_W + 1)'(NUM_CH));

  // One-cycle error pulse for writes aimed past the last channel.
  always_ff @(posedge clk_in) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= bus.cfg_we && !ch_ok;
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr;
      assign wr = bus.cfg_we && ch_ok && (bus.cfg_ch == CH_W'(i));

      clkdiv_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk_in       (clk_in),
        .rst          (rst),
        .en           (bus.en[i]),
        .sync_restart (bus.sync_restart),
        .wr           (wr),
        .wdata        (bus.cfg_div),
        .pending      (pending[i]),
        .tick         (tick[i]),
        .clk_out      (clk_out[i])
      );
    end
  endgenerate

  assign bus.cfg_err = cfg_err;
  assign bus.pending = pending;
  assign bus.tick    = tick;
  assign bus.clk_out = clk_out;

endmodule : clock_divider_bank

`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
// ============================================================================
//  tb_clock_divider_bank
//  Scoreboard bench: each stimulus cycle pushes the expected output snapshot
//  from a countdown reference model; a monitor pops and compares every cycle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clock_divider_bank;
  import clkdiv_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int DEF    = 1042;
  localparam int CH_W   = clog2_min1(NUM_CH);

  typedef logic [3*NUM_CH:0] snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_divider_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clock_divider_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  snap_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  // Reference model: each channel counts down the cycles left until its tick.
  int rem  [NUM_CH];
  int act  [NUM_CH];
  int shd  [NUM_CH];
  bit pend [NUM_CH];
  bit clko [NUM_CH];
  bit tk   [NUM_CH];
  bit err;

  task automatic model_edge();
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rem[c] = DEF; act[c] = DEF; shd[c] = 0;
        pend[c] = 0; clko[c] = 1; tk[c] = 0;
      end
      err = 0;
      return;
    end
    err = bus.cfg_we && (int'(bus.cfg_ch) >= NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      bit wr;
      int wd;
      wr = bus.cfg_we && (int'(bus.cfg_ch) == c);
      wd = int'(bus.cfg_div);
      tk[c] = 0;
      if (bus.sync_restart) begin
        if (wr)           act[c] = wd;
        else if (pend[c]) act[c] = shd[c];
        pend[c] = 0;
        clko[c] = 1;
        rem[c]  = act[c];
      end else if (wr && (!bus.en[c] || act[c] == 0)) begin
        act[c]  = wd;
        rem[c]  = wd;
        pend[c] = 0;
      end else if (bus.en[c] && act[c] != 0) begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) begin
          tk[c]   = 1;
          clko[c] = !clko[c];
          if (pend[c]) begin
            act[c]  = shd[c];
            pend[c] = 0;
          end
          rem[c] = act[c];
        end
        if (wr) begin
          shd[c]  = wd;
          pend[c] = 1;
        end
      end
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s[3*NUM_CH] = err;
    for (int c = 0; c < NUM_CH; c++) begin
      s[2*NUM_CH + c] = pend[c];
      s[NUM_CH + c]   = tk[c];
      s[c]            = clko[c];
    end
    return s;
  endfunction

  // Inputs are set before this call; it predicts the next edge and advances.
  task automatic step();
    model_edge();
    exp_q.push_back(model_snap());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic write(input int ch, input int d);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = CH_W'(ch);
    bus.cfg_div = CNT_W'(d);
    step();
    bus.cfg_we  = 1'b0;
  endtask

  // Monitor: compare the DUT against the oldest prediction after every edge.
  initial begin
    snap_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.cfg_err, bus.pending, bus.tick, bus.clk_out};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d {err,pend,tick,clk} got=%b exp=%b", cyc, a, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    bus.en           = '1;
    bus.sync_restart = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_ch       = '0;
    bus.cfg_div      = '0;

    // Reset values, then default divisor: ticks every 1042, clk_out period 2084.
    run(3);
    rst = 1'b0;
    run(2 * DEF + 5);

    // Running at 10, write 4 mid-period: shadowed until the terminal count.
    bus.en[0] = 1'b0;
    write(0, 10);
    bus.en[0] = 1'b1;
    run(3);
    write(0, 4);
    run(30);

    // Disabled channel: write is immediate, first tick 5 cycles after enable.
    bus.en[0] = 1'b0;
    run(2);
    write(0, 5);
    run(3);
    bus.en[0] = 1'b1;
    run(12);

    // Write 0 halts at the boundary; then 1 applies at once (tick held high).
    write(0, 0);
    run(12);
    write(0, 1);
    run(6);

    // Two channels at 6 and 9, then a synchronous restart.
    bus.en = '0;
    write(0, 6);
    write(1, 9);
    bus.en = '1;
    run(7);
    bus.sync_restart = 1'b1;
    step();
    bus.sync_restart = 1'b0;
    run(20);

    // Out-of-range channel write, then a mid-period reset.
    write(NUM_CH, 7);
    run(3);
    write(NUM_CH + 0, 2);
    run(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(5);

    // Randomized traffic with small divisors so boundaries occur often.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) bus.en[c] = ($urandom_range(0, 9) != 0);
      bus.cfg_we       = ($urandom_range(0, 6) == 0);
      bus.cfg_ch       = CH_W'($urandom_range(0, NUM_CH));
      bus.cfg_div      = CNT_W'($urandom_range(0, 12));
      bus.sync_restart = ($urandom_range(0, 49) == 0);
      rst              = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.cfg_we       = 1'b0;
    bus.sync_restart = 1'b0;
    rst              = 1'b0;
    run(2);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_clock_divider_bank

`default_nettype wire
